// File: rtl/compress_handler.sv
// compress_handler: run-length encoder feeding the compressed-output path.
// Reads a block of 16-bit RAM words, scans them MSB-first as one bit stream
// and emits 8-bit codes {bit value, run length} over a valid/ready stream.
// Optional build macro: COMPRESS_STATS_EN adds the codeCount output.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for start
// READ_REQ  | read strobe for the current word address
// READ_WAIT | RAM data arrives, load shift register
// SCAN      | consume one bit per cycle, emit a code when a run breaks
// FLUSH     | emit the last open run of the job
// DONE      | wait for the final code to leave, pulse done
module compress_handler #(
   parameter int ADDR_W  = 16,
   parameter int MAX_RUN = 127   // must lie in 1..127, the code holds 7 length bits
) (
   input  logic              clk,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] startAddr,
   input  logic [15:0]       wordCount,
   output logic [ADDR_W-1:0] ramAddress,
   output logic              ramReadSignal,
   input  logic [15:0]       ramDataIn,
   output logic [7:0]        code,
   output logic              codeValid,
   input  logic              codeReady,
   output logic              busy,
   output logic              done
`ifdef COMPRESS_STATS_EN
   ,
   output logic [15:0]       codeCount
`endif
);

   localparam logic [6:0] MAX_RUN_L = 7'(MAX_RUN);

   typedef enum logic [2:0] {
      IDLE,
      READ_REQ,
      READ_WAIT,
      SCAN,
      FLUSH,
      DONE
   } stateT;

   stateT state;
   stateT stateNext;

   logic [ADDR_W-1:0] addrReg;
   logic [15:0]       wordsLeft;
   logic [15:0]       shiftReg;
   logic [3:0]        bitPtr;
   logic              runBit;
   logic [6:0]        runLen;
   logic              firstBit;
   logic [7:0]        codeReg;
   logic              codeValidReg;

   logic              slotFree;
   logic              curBit;
   logic              runBreak;
   logic              acceptStart;
   logic              captureWord;
   logic              consumeBit;
   logic              advanceWord;
   logic              emit;
   logic [7:0]        emitCode;

   // The output slot can take a new code if it is empty or being drained now.
   assign slotFree = !codeValidReg || codeReady;
   assign curBit   = shiftReg[15];
   // A run closes when the bit changes or the run has reached its length cap.
   assign runBreak = !firstBit && ((curBit != runBit) || (runLen == MAX_RUN_L));

   assign ramAddress    = addrReg;
   assign ramReadSignal = (state == READ_REQ);
   assign code          = codeReg;
   assign codeValid     = codeValidReg;
   assign busy          = (state != IDLE);
   // done waits until the last code of the job is accepted.
   assign done          = (state == DONE) && slotFree;

   // State register.
   always_ff @(posedge clk) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // Next-state and per-cycle control decisions.
   always_comb begin
      stateNext   = state;
      acceptStart = 1'b0;
      captureWord = 1'b0;
      consumeBit  = 1'b0;
      advanceWord = 1'b0;
      emit        = 1'b0;
      emitCode    = {runBit, runLen};
      case (state)
         IDLE: begin
            if (start) begin
               acceptStart = 1'b1;
               stateNext   = (wordCount == 16'd0) ? DONE : READ_REQ;
            end
         end
         READ_REQ: begin
            stateNext = READ_WAIT;
         end
         READ_WAIT: begin
            captureWord = 1'b1;
            stateNext   = SCAN;
         end
         SCAN: begin
            // A bit that closes a run must wait for room in the output slot.
            if (!runBreak || slotFree) begin
               consumeBit = 1'b1;
               emit       = runBreak;
               if (bitPtr == 4'd0) begin
                  if (wordsLeft == 16'd1) begin
                     stateNext = FLUSH;
                  end else begin
                     advanceWord = 1'b1;
                     stateNext   = READ_REQ;
                  end
               end
            end
         end
         FLUSH: begin
            if (slotFree) begin
               emit      = 1'b1;
               stateNext = DONE;
            end
         end
         DONE: begin
            if (slotFree) begin
               stateNext = IDLE;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Job bookkeeping: address and remaining-word down-counter.
   always_ff @(posedge clk) begin
      if (RST) begin
         addrReg   <= '0;
         wordsLeft <= 16'd0;
      end else if (acceptStart) begin
         addrReg   <= startAddr;
         wordsLeft <= wordCount;
      end else if (advanceWord) begin
         addrReg   <= addrReg + 1'b1;
         wordsLeft <= wordsLeft - 16'd1;
      end
   end

   // Word shift register and bit pointer.
   always_ff @(posedge clk) begin
      if (RST) begin
         shiftReg <= 16'd0;
         bitPtr   <= 4'd0;
      end else if (captureWord) begin
         shiftReg <= ramDataIn;
         bitPtr   <= 4'd15;
      end else if (consumeBit) begin
         shiftReg <= {shiftReg[14:0], 1'b0};
         bitPtr   <= bitPtr - 4'd1;
      end
   end

   // Open run tracking; a job starts with no open run.
   always_ff @(posedge clk) begin
      if (RST) begin
         runBit   <= 1'b0;
         runLen   <= 7'd0;
         firstBit <= 1'b0;
      end else if (acceptStart) begin
         runBit   <= 1'b0;
         runLen   <= 7'd0;
         firstBit <= 1'b1;
      end else if (consumeBit) begin
         firstBit <= 1'b0;
         if (firstBit || runBreak) begin
            runBit <= curBit;
            runLen <= 7'd1;
         end else begin
            runLen <= runLen + 7'd1;
         end
      end
   end

   // Single-entry output slot with valid/ready handshake.
   always_ff @(posedge clk) begin
      if (RST) begin
         codeReg      <= 8'd0;
         codeValidReg <= 1'b0;
      end else if (emit) begin
         codeReg      <= emitCode;
         codeValidReg <= 1'b1;
      end else if (codeReady) begin
         codeValidReg <= 1'b0;
      end
   end

`ifdef COMPRESS_STATS_EN
   // Saturating count of codes accepted by the consumer in this job.
   always_ff @(posedge clk) begin
      if (RST) begin
         codeCount <= 16'd0;
      end else if (acceptStart) begin
         codeCount <= 16'd0;
      end else if (codeValidReg && codeReady && (codeCount != 16'hFFFF)) begin
         codeCount <= codeCount + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_compress_handler.sv
// Testbench for compress_handler: scoreboard of expected codes and read
// addresses, filled from a bit-stream run-length model, drained by a monitor.
`timescale 1ns/1ps
module tb_compress_handler;

   localparam int ADDR_W  = 16;
   localparam int MAX_RUN = 127;

   logic              clk = 1'b0;
   logic              RST = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] startAddr = '0;
   logic [15:0]       wordCount = 16'd0;
   logic [ADDR_W-1:0] ramAddress;
   logic              ramReadSignal;
   logic [15:0]       ramDataIn = 16'd0;
   logic [7:0]        code;
   logic              codeValid;
   logic              codeReady = 1'b1;
   logic              busy;
   logic              done;
`ifdef COMPRESS_STATS_EN
   logic [15:0]       codeCount;
`endif

   compress_handler #(.ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN)) dut (
      .clk(clk),
      .RST(RST),
      .start(start),
      .startAddr(startAddr),
      .wordCount(wordCount),
      .ramAddress(ramAddress),
      .ramReadSignal(ramReadSignal),
      .ramDataIn(ramDataIn),
      .code(code),
      .codeValid(codeValid),
      .codeReady(codeReady),
      .busy(busy),
      .done(done)
`ifdef COMPRESS_STATS_EN
      ,
      .codeCount(codeCount)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:65535];
   logic [15:0] jobWords[$];
   logic [7:0]  expCodes[$];
   logic [15:0] expAddr[$];

   int errors = 0;
   int checks = 0;
   int readCount = 0;
   int xferCount = 0;
   int readyMode = 0;
   bit stallPrev = 1'b0;
   logic [7:0] prevCode = 8'd0;

   task automatic checkEq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: split the MSB-first bit stream into maximal runs, then cut
   // each run into MAX_RUN-sized chunks.
   function automatic void refEncode();
      bit          bits[$];
      logic [15:0] w;
      int          i;
      int          len;
      int          c;
      bit          b;
      foreach (jobWords[j]) begin
         w = jobWords[j];
         for (int k = 15; k >= 0; k--) bits.push_back(w[k]);
      end
      i = 0;
      while (i < bits.size()) begin
         b = bits[i];
         len = 0;
         while (i < bits.size() && bits[i] == b) begin
            len++;
            i++;
         end
         while (len > 0) begin
            c = (len > MAX_RUN) ? MAX_RUN : len;
            expCodes.push_back({b, 7'(c)});
            len -= c;
         end
      end
   endfunction

   // RAM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (ramReadSignal) ramDataIn <= mem[ramAddress];
   end

   // Consumer readiness: 0 always ready, 1 random, 2 held low.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (readyMode)
            0:       codeReady = 1'b1;
            1:       codeReady = ($urandom_range(3) != 0);
            default: codeReady = 1'b0;
         endcase
      end
   end

   // Monitor: read addresses, held-code stability and transferred codes.
   always @(negedge clk) begin
      if (RST) begin
         stallPrev = 1'b0;
      end else begin
         if (ramReadSignal) begin
            readCount++;
            checkEq("read_expected", int'(expAddr.size() > 0), 1);
            if (expAddr.size() > 0) checkEq("read_addr", ramAddress, expAddr.pop_front());
         end
         if (stallPrev) begin
            checkEq("code_hold_valid", codeValid, 1);
            checkEq("code_hold_value", code, prevCode);
         end
         if (codeValid && codeReady) begin
            xferCount++;
            checkEq("code_expected", int'(expCodes.size() > 0), 1);
            if (expCodes.size() > 0) checkEq("code_value", code, expCodes.pop_front());
         end
         stallPrev = codeValid && !codeReady;
         prevCode  = code;
      end
   end

   task automatic prepJob(input logic [15:0] sa, input bit useModel);
      logic [15:0] a;
      for (int i = 0; i < jobWords.size(); i++) begin
         a = sa + 16'(i);
         mem[a] = jobWords[i];
         expAddr.push_back(a);
      end
      if (useModel) refEncode();
   endtask

   task automatic runJob(input logic [15:0] sa, input bit useModel, input bit checkTiming);
      int n;
      int cyc;
      int readsBefore;
      int xfersBefore;
      int nExp;
      n = jobWords.size();
      prepJob(sa, useModel);
      nExp = expCodes.size();
      readsBefore = readCount;
      xfersBefore = xferCount;
      startAddr = sa;
      wordCount = 16'(n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         #1;
         cyc++;
      end while (!done && cyc < 20000);
      checkEq("done_seen", done, 1);
      checkEq("busy_at_done", busy, 1);
      checkEq("codes_left_at_done", expCodes.size(), 0);
      checkEq("reads_per_job", readCount - readsBefore, n);
      checkEq("codes_per_job", xferCount - xfersBefore, nExp);
      if (checkTiming) checkEq("job_cycles", cyc, (n == 0) ? 1 : 18 * n + 2);
      @(negedge clk);
      #1;
      checkEq("done_pulse_width", done, 0);
      checkEq("busy_after_done", busy, 0);
      checkEq("codevalid_after_done", codeValid, 0);
`ifdef COMPRESS_STATS_EN
      checkEq("code_count", codeCount, nExp);
`endif
      expCodes.delete();
      expAddr.delete();
   endtask

   initial begin
      int sawDone;
      int readsAt;
      int k;
      int n;
      int r;
      // Reset, with a start request that coincides with reset.
      RST = 1'b1;
      start = 1'b1;
      wordCount = 16'd3;
      repeat (3) @(posedge clk);
      #1;
      RST = 1'b0;
      start = 1'b0;
      wordCount = 16'd0;
      @(negedge clk);
      checkEq("rst_ramAddress", ramAddress, 0);
      checkEq("rst_ramReadSignal", ramReadSignal, 0);
      checkEq("rst_code", code, 0);
      checkEq("rst_codeValid", codeValid, 0);
      checkEq("rst_busy", busy, 0);
      checkEq("rst_done", done, 0);
`ifdef COMPRESS_STATS_EN
      checkEq("rst_codeCount", codeCount, 0);
`endif
      @(posedge clk);
      #1;

      // Single word 0xFF00.
      jobWords = '{16'hFF00};
      expCodes = '{8'h88, 8'h08};
      runJob(16'h0010, 1'b0, 1'b1);

      // 128 zeros split at MAX_RUN.
      jobWords = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      expCodes = '{8'h7F, 8'h01};
      runJob(16'h0200, 1'b0, 1'b1);

      // Alternating bits.
      jobWords = '{16'hAAAA};
      expCodes.delete();
      for (int i = 0; i < 8; i++) begin
         expCodes.push_back(8'h81);
         expCodes.push_back(8'h01);
      end
      runJob(16'h0300, 1'b0, 1'b1);

      // Empty job.
      jobWords.delete();
      expCodes.delete();
      runJob(16'h0400, 1'b0, 1'b1);

      // Backpressure on the first code.
      readyMode = 2;
      repeat (2) @(posedge clk);
      #1;
      jobWords = '{16'hF0F0};
      expCodes = '{8'h84, 8'h04, 8'h84, 8'h04};
      fork
         begin
            k = 0;
            while (!codeValid && k < 500) begin
               @(negedge clk);
               k++;
            end
            readsAt = readCount;
            repeat (5) @(negedge clk);
            checkEq("stall_code", code, 8'h84);
            checkEq("stall_valid", codeValid, 1);
            checkEq("stall_no_read", readCount - readsAt, 0);
            readyMode = 0;
         end
      join_none
      runJob(16'h0500, 1'b0, 1'b0);

      // Address wrap.
      jobWords = '{16'h1234, 16'hBEEF};
      runJob(16'hFFFF, 1'b1, 1'b1);

      // 128 ones.
      jobWords = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      expCodes = '{8'hFF, 8'h81};
      runJob(16'h0600, 1'b0, 1'b1);

      // Reset in the middle of SCAN.
      jobWords = '{16'h1234, 16'hFFFF, 16'h00F0};
      prepJob(16'h0700, 1'b1);
      startAddr = 16'h0700;
      wordCount = 16'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      RST = 1'b1;
      expCodes.delete();
      expAddr.delete();
      @(posedge clk);
      #1;
      checkEq("midrst_ramAddress", ramAddress, 0);
      checkEq("midrst_ramReadSignal", ramReadSignal, 0);
      checkEq("midrst_code", code, 0);
      checkEq("midrst_codeValid", codeValid, 0);
      checkEq("midrst_busy", busy, 0);
      checkEq("midrst_done", done, 0);
`ifdef COMPRESS_STATS_EN
      checkEq("midrst_codeCount", codeCount, 0);
`endif
      RST = 1'b0;
      sawDone = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) sawDone++;
      end
      checkEq("midrst_no_done", sawDone, 0);
      @(posedge clk);
      #1;
      jobWords = '{16'h0F0F, 16'h8001};
      runJob(16'h0800, 1'b1, 1'b1);

      // Randomized jobs.
      for (int j = 0; j < 40; j++) begin
         n = $urandom_range(4);
         jobWords.delete();
         for (int i = 0; i < n; i++) begin
            r = $urandom_range(3);
            if (r == 0)      jobWords.push_back(16'h0000);
            else if (r == 1) jobWords.push_back(16'hFFFF);
            else             jobWords.push_back(16'($urandom));
         end
         readyMode = $urandom_range(1);
         @(posedge clk);
         #1;
         runJob(16'($urandom), 1'b1, readyMode == 0);
         readyMode = 0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
